// File: rtl/memory_island_pkg.sv
// Shared constants and types for the memory island wide responder.
// The legal SRAM latency range lives here so sibling blocks can reuse it.
package memory_island_pkg;

    localparam int unsigned SRAM_LATENCY_MIN = 1;
    localparam int unsigned SRAM_LATENCY_MAX = 4;

    // Bookkeeping carried down the latency pipeline alongside each accepted request.
    typedef struct packed {
        logic valid;
        logic oor;
        logic we;
    } rsp_tag_t;

    // Keeps address ports at least one bit wide for single-word banks.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/memory_island_delay.sv
// Fixed-depth shift register with synchronous active-low clear.
// Used to carry response tags in step with the SRAM read latency.
module memory_island_delay #(
    parameter int unsigned Depth = 1,
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout
);

    logic [Depth-1:0][Width-1:0] stage_reg;
    logic [Depth-1:0][Width-1:0] stage_next;

    for (genvar gi = 0; gi < Depth; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_next[gi] = din;
        end else begin : g_tail
            assign stage_next[gi] = stage_reg[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign dout = stage_reg[Depth-1];

endmodule

// File: rtl/memory_island_wide_responder.sv
// Wide subordinate port in front of one SRAM bank: forwards in-range requests,
// answers out-of-range ones locally, and returns one in-order response per handshake.
module memory_island_wide_responder
    import memory_island_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned WideDataWidth = 64,
    parameter int unsigned WideStrbWidth = WideDataWidth / 8,
    parameter int unsigned NumWords      = 1024,
    parameter int unsigned SramLatency   = 1,
    parameter int unsigned RspReg        = 0,
    localparam int unsigned SramAddrWidth = clog2_min1(NumWords)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wide_req_i,
    output logic                     wide_gnt_o,
    input  logic [AddrWidth-1:0]     wide_addr_i,
    input  logic                     wide_we_i,
    input  logic [WideDataWidth-1:0] wide_wdata_i,
    input  logic [WideStrbWidth-1:0] wide_strb_i,
    output logic                     wide_rvalid_o,
    output logic [WideDataWidth-1:0] wide_rdata_o,
    output logic                     sram_req_o,
    input  logic                     sram_gnt_i,
    output logic [SramAddrWidth-1:0] sram_addr_o,
    output logic                     sram_we_o,
    output logic [WideDataWidth-1:0] sram_wdata_o,
    output logic [WideStrbWidth-1:0] sram_be_o,
    input  logic [WideDataWidth-1:0] sram_rdata_i,
    output logic                     busy_o
);

    localparam int unsigned OffWidth = $clog2(WideStrbWidth);
    localparam int unsigned IdxWidth = AddrWidth - OffWidth;
    localparam int unsigned CntWidth = $clog2(SramLatency + RspReg + 2);

    if (SramLatency < SRAM_LATENCY_MIN || SramLatency > SRAM_LATENCY_MAX) begin : g_bad_latency
        $error("memory_island_wide_responder: SramLatency must be within 1..4");
    end
    if (NumWords == 0) begin : g_bad_depth
        $error("memory_island_wide_responder: NumWords must be greater than zero");
    end
    if (WideDataWidth % 8 != 0) begin : g_bad_width
        $error("memory_island_wide_responder: WideDataWidth must be a multiple of 8");
    end

    logic [IdxWidth-1:0] word_idx;
    logic                oor;
    logic                handshake;

    assign word_idx = wide_addr_i[AddrWidth-1:OffWidth];
    // One extra bit so a bank covering the whole index space never reads as out of range.
    assign oor      = {1'b0, word_idx} >= (IdxWidth + 1)'(NumWords);

    if (OffWidth > 0) begin : g_offset_sink
        logic unused_offset_bits;
        assign unused_offset_bits = ^wide_addr_i[OffWidth-1:0];
    end

    // Request path stays purely combinational so a grant never costs a cycle.
    assign wide_gnt_o   = wide_req_i & (oor | sram_gnt_i);
    assign sram_req_o   = wide_req_i & ~oor;
    assign sram_addr_o  = word_idx[SramAddrWidth-1:0];
    assign sram_we_o    = wide_we_i;
    assign sram_wdata_o = wide_wdata_i;
    assign sram_be_o    = wide_strb_i;
    assign handshake    = wide_req_i & wide_gnt_o;

    rsp_tag_t tag_in;
    rsp_tag_t tag_out;

    assign tag_in = '{valid: handshake, oor: oor, we: wide_we_i};

    memory_island_delay #(
        .Depth (SramLatency),
        .Width ($bits(rsp_tag_t))
    ) u_tag_delay (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .din   (tag_in),
        .dout  (tag_out)
    );

    logic                     rsp_valid;
    logic [WideDataWidth-1:0] rsp_data;

    // Only an in-range read carries bank data; everything else answers with zero.
    assign rsp_valid = tag_out.valid;
    assign rsp_data  = (tag_out.valid && !tag_out.oor && !tag_out.we) ? sram_rdata_i : '0;

    if (RspReg != 0) begin : g_rsp_reg
        logic                     rvalid_reg;
        logic [WideDataWidth-1:0] rdata_reg;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                rvalid_reg <= 1'b0;
                rdata_reg  <= '0;
            end else begin
                rvalid_reg <= rsp_valid;
                rdata_reg  <= rsp_data;
            end
        end

        assign wide_rvalid_o = rvalid_reg;
        assign wide_rdata_o  = rdata_reg;
    end else begin : g_rsp_direct
        assign wide_rvalid_o = rsp_valid;
        assign wide_rdata_o  = rsp_data;
    end

    logic [CntWidth-1:0] outstanding_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outstanding_reg <= '0;
        end else if (handshake && !wide_rvalid_o) begin
            outstanding_reg <= outstanding_reg + CntWidth'(1);
        end else if (!handshake && wide_rvalid_o) begin
            outstanding_reg <= outstanding_reg - CntWidth'(1);
        end
    end

    assign busy_o = (outstanding_reg != '0);

endmodule

// File: tb/tb_memory_island_wide_responder.sv
// Scoreboard bench: instance 0 uses latency 1 without output register,
// instance 1 uses latency 3 with output register; each has its own SRAM model.
module tb_memory_island_wide_responder;

    localparam int NUM_INST = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n  [NUM_INST];
    logic        req    [NUM_INST];
    logic [31:0] addr   [NUM_INST];
    logic        we     [NUM_INST];
    logic [63:0] wdata  [NUM_INST];
    logic [7:0]  strb   [NUM_INST];
    logic        sgnt   [NUM_INST];
    logic        gnt    [NUM_INST];
    logic        rvalid [NUM_INST];
    logic [63:0] rdata  [NUM_INST];
    logic        busy   [NUM_INST];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic string tg(input int i, input string s);
        return $sformatf("i%0d_%s", i, s);
    endfunction

    for (genvar gi = 0; gi < NUM_INST; gi++) begin : g_inst
        localparam int unsigned LAT = (gi == 0) ? 1 : 3;
        localparam int unsigned RSP = (gi == 0) ? 0 : 1;

        logic        sreq;
        logic        swe;
        logic [9:0]  saddr;
        logic [63:0] swdata;
        logic [7:0]  sbe;
        logic [63:0] srdata;
        logic [63:0] sram_mem [1024];
        logic [63:0] ref_mem  [1024];
        logic [63:0] rd_pipe  [LAT];
        logic [63:0] exp_data_q [$];
        int          exp_due_q  [$];

        memory_island_wide_responder #(
            .SramLatency (LAT),
            .RspReg      (RSP)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n[gi]),
            .wide_req_i    (req[gi]),
            .wide_gnt_o    (gnt[gi]),
            .wide_addr_i   (addr[gi]),
            .wide_we_i     (we[gi]),
            .wide_wdata_i  (wdata[gi]),
            .wide_strb_i   (strb[gi]),
            .wide_rvalid_o (rvalid[gi]),
            .wide_rdata_o  (rdata[gi]),
            .sram_req_o    (sreq),
            .sram_gnt_i    (sgnt[gi]),
            .sram_addr_o   (saddr),
            .sram_we_o     (swe),
            .sram_wdata_o  (swdata),
            .sram_be_o     (sbe),
            .sram_rdata_i  (srdata),
            .busy_o        (busy[gi])
        );

        initial begin
            for (int k = 0; k < 1024; k++) begin
                sram_mem[k] <= 64'd0;
                ref_mem[k] = 64'd0;
            end
            for (int k = 0; k < int'(LAT); k++) rd_pipe[k] <= 64'd0;
        end

        // Bank model: byte-enabled writes, reads visible LAT cycles after the grant.
        always @(posedge clk) begin
            if (sreq && sgnt[gi]) begin
                if (swe) begin
                    for (int b = 0; b < 8; b++)
                        if (sbe[b]) sram_mem[saddr][b*8 +: 8] <= swdata[b*8 +: 8];
                end else begin
                    rd_pipe[0] <= sram_mem[saddr];
                end
            end
            for (int k = 1; k < int'(LAT); k++) rd_pipe[k] <= rd_pipe[k-1];
        end

        assign srdata = rd_pipe[LAT-1];

        always @(negedge clk) begin : mon
            logic [28:0] idx;
            logic        oor_m;
            logic [63:0] d;
            int          due;
            idx   = addr[gi][31:3];
            oor_m = (idx >= 29'd1024);

            check_eq(tg(gi, "busy"), 64'(busy[gi]), 64'(exp_data_q.size() != 0));
            check_eq(tg(gi, "outstanding"), 64'(u_dut.outstanding_reg), 64'(exp_data_q.size()));
            cnt_bound: assert (int'(u_dut.outstanding_reg) <= int'(LAT + RSP))
                else check_eq(tg(gi, "cnt_bound"), 64'(u_dut.outstanding_reg), 64'(LAT + RSP));

            if (!rst_n[gi]) begin
                exp_data_q.delete();
                exp_due_q.delete();
            end

            if (rvalid[gi]) begin
                if (exp_data_q.size() == 0) begin
                    check_eq(tg(gi, "spurious_rvalid"), 64'(rvalid[gi]), 64'd0);
                end else begin
                    d   = exp_data_q.pop_front();
                    due = exp_due_q.pop_front();
                    check_eq(tg(gi, "rdata"), rdata[gi], d);
                    check_eq(tg(gi, "latency"), 64'(cyc), 64'(due));
                    $display("i%0d rsp cycle=%0d rdata=%h", gi, cyc, rdata[gi]);
                end
            end else begin
                check_eq(tg(gi, "idle_rdata"), rdata[gi], 64'd0);
            end

            check_eq(tg(gi, "gnt"), 64'(gnt[gi]), 64'(req[gi] & (oor_m | sgnt[gi])));
            check_eq(tg(gi, "sram_req"), 64'(sreq), 64'(req[gi] & ~oor_m));
            if (sreq) begin
                check_eq(tg(gi, "sram_fwd"), 64'({saddr, swe, sbe}), 64'({idx[9:0], we[gi], strb[gi]}));
                check_eq(tg(gi, "sram_wdata"), swdata, wdata[gi]);
            end

            if (req[gi] && gnt[gi] && rst_n[gi]) begin
                if (we[gi]) begin
                    d = 64'd0;
                    if (!oor_m)
                        for (int b = 0; b < 8; b++)
                            if (strb[gi][b]) ref_mem[idx[9:0]][b*8 +: 8] = wdata[gi][b*8 +: 8];
                end else begin
                    d = oor_m ? 64'd0 : ref_mem[idx[9:0]];
                end
                exp_data_q.push_back(d);
                exp_due_q.push_back(cyc + int'(LAT + RSP));
            end
        end
    end

    task automatic drive(input int i, input bit w, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] s);
        req[i]   = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        strb[i]  = s;
    endtask

    // Holds the request until granted, then returns just after the next rising edge.
    task automatic issue(input int i, input bit w, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] s);
        int waited;
        waited = 0;
        drive(i, w, a, d, s);
        @(negedge clk);
        while (!gnt[i]) begin
            if (waited == 20) begin
                check_eq(tg(i, "gnt_timeout"), 64'(gnt[i]), 64'd1);
                break;
            end
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        $display("i%0d req cycle=%0d we=%0d addr=%h wdata=%h strb=%h", i, cyc, w, a, d, s);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int i, input int n);
        req[i] = 1'b0;
        we[i]  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_INST; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; addr[i] = '0; we[i] = 1'b0;
            wdata[i] = '0;   strb[i] = '0;  sgnt[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NUM_INST; i++) rst_n[i] = 1'b1;

        // Write then read back a full word.
        issue(0, 1'b1, 32'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        issue(0, 1'b0, 32'h10, 64'd0, 8'h00);
        idle(0, 3);

        // Partial strobe write, then read through a different byte offset of the same word.
        issue(0, 1'b1, 32'h10, 64'h11223344_55667788, 8'h0F);
        issue(0, 1'b0, 32'h14, 64'd0, 8'h00);
        idle(0, 2);

        // Out-of-range read is granted even with the bank refusing.
        sgnt[0] = 1'b0;
        issue(0, 1'b0, 32'h2000, 64'd0, 8'h00);
        idle(0, 2);
        sgnt[0] = 1'b1;

        // Out-of-range write aliasing word 0 must not disturb the bank.
        issue(0, 1'b1, 32'h0, 64'hA5A5A5A5_5A5A5A5A, 8'hFF);
        issue(0, 1'b1, 32'h2000, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
        issue(0, 1'b0, 32'h0, 64'd0, 8'h00);
        issue(0, 1'b1, 32'h1FF8, 64'h0123456789ABCDEF, 8'hFF);
        issue(0, 1'b0, 32'h1FF8, 64'd0, 8'h00);
        issue(0, 1'b0, 32'hFFFF_FFF8, 64'd0, 8'h00);
        idle(0, 3);

        // Bank stalls three cycles with a read pending.
        drive(0, 1'b0, 32'h1FF8, 64'd0, 8'h00);
        sgnt[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq(tg(0, "stall_gnt"), 64'(gnt[0]), 64'd0);
            @(posedge clk); #1;
        end
        sgnt[0] = 1'b1;
        issue(0, 1'b0, 32'h1FF8, 64'd0, 8'h00);
        idle(0, 4);

        // Deep pipeline: 8 back-to-back writes then 8 back-to-back reads.
        for (int k = 0; k < 8; k++)
            issue(1, 1'b1, 32'(k * 8), {$urandom, $urandom}, 8'hFF);
        for (int k = 0; k < 8; k++)
            issue(1, 1'b0, 32'(k * 8), 64'd0, 8'h00);
        idle(1, 8);

        // Mixed random traffic on both instances.
        for (int k = 0; k < 24; k++) begin
            int inst;
            inst = k % 2;
            issue(inst, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 32'h2000 + 32'($urandom_range(0, 15) * 8)
                                              : 32'($urandom_range(0, 15) * 8),
                  {$urandom, $urandom}, 8'($urandom));
            idle(inst, 0);
        end
        idle(0, 0);
        idle(1, 8);

        // Reset with two reads in flight: both responses are dropped.
        issue(1, 1'b0, 32'h0, 64'd0, 8'h00);
        issue(1, 1'b0, 32'h8, 64'd0, 8'h00);
        req[1]   = 1'b0;
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        idle(1, 8);
        issue(1, 1'b0, 32'h8, 64'd0, 8'h00);
        idle(1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_island_wide_responder.md
MEMORY_ISLAND_WIDE_RESPONDER -- requirements
Module: memory_island_wide_responder

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, meaning the byte address width of the wide port.
REQ-002 SHALL have parameter WideDataWidth, default 64, meaning the data width of the wide port and SRAM in bits.
REQ-003 SHALL have parameter WideStrbWidth, default WideDataWidth/8, meaning the derived byte-enable width, which is not overridden.
REQ-004 SHALL have parameter NumWords, default 1024, meaning the bank depth in words.
REQ-005 SHALL have parameter SramLatency, default 1, meaning the SRAM read latency in cycles, legal range 1..4.
REQ-006 SHALL have parameter RspReg, default 0, meaning that 1 adds one output register stage.
REQ-007 SHALL have port clk_i, input, 1 bit, meaning the single clock.
REQ-008 SHALL have port rst_ni, input, 1 bit, meaning reset, which is synchronous and active-low.
REQ-009 SHALL have ports wide_req_i (in, 1), wide_gnt_o (out, 1), wide_addr_i (in, AddrWidth), wide_we_i (in, 1), wide_wdata_i (in, WideDataWidth) and wide_strb_i (in, WideStrbWidth), meaning the request side of the wide subordinate port.
REQ-010 SHALL have ports wide_rvalid_o (out, 1) and wide_rdata_o (out, WideDataWidth), meaning the response side; the port has no rready.
REQ-011 SHALL have ports sram_req_o (out, 1), sram_gnt_i (in, 1), sram_addr_o (out, clog2(NumWords)), sram_we_o (out, 1), sram_wdata_o (out, WideDataWidth), sram_be_o (out, WideStrbWidth) and sram_rdata_i (in, WideDataWidth), meaning the bank interface.
REQ-012 SHALL have port busy_o, output, 1 bit, meaning that at least one response is outstanding.

Function
REQ-013 SHALL compute word index = wide_addr_i[AddrWidth-1:clog2(WideStrbWidth)], ignoring the low byte-offset bits.
REQ-014 SHALL flag a request as out-of-range (OOR) when word index >= NumWords.
REQ-015 SHALL drive wide_gnt_o combinationally: wide_req_i & (OOR | sram_gnt_i).
REQ-016 SHALL drive sram_req_o = wide_req_i & ~OOR.
REQ-017 SHALL drive sram_addr_o with the truncated word index and pass we, wdata and strb to the SRAM unmodified.
REQ-018 SHALL count a handshake as wide_req_i & wide_gnt_o and SHALL accept at most one per cycle, back-to-back with no bubbles.
REQ-019 SHALL produce exactly one wide_rvalid_o pulse per handshake, for reads and writes alike, in issue order.
REQ-020 SHALL assert wide_rvalid_o exactly SramLatency+RspReg cycles after the handshake cycle.
REQ-021 SHALL track per-stage valid and OOR flags in a SramLatency-deep shift register.
REQ-022 SHALL return wide_rdata_o = sram_rdata_i for an in-range read.
REQ-023 SHALL return wide_rdata_o = 0 for an OOR read and SHALL never forward an OOR write to the SRAM.
REQ-024 SHALL return write-response wide_rdata_o = 0.
REQ-025 SHALL keep wide_rdata_o = 0 whenever wide_rvalid_o is low.
REQ-026 SHALL keep an outstanding counter of width clog2(SramLatency+RspReg+2), incrementing on handshake and decrementing on rvalid.
REQ-027 SHALL leave the outstanding counter unchanged when a handshake and an rvalid occur in the same cycle.
REQ-028 SHALL drive busy_o = (counter != 0).
REQ-029 SHALL never overflow or underflow the outstanding counter, and the bench SHALL check this by assertion.
REQ-030 SHALL, when sram_gnt_i is low with an in-range request, issue no handshake; the in-flight pipeline SHALL keep advancing unaffected.

Reset
REQ-031 SHALL, while rst_ni is low at a clock edge, clear all pipeline valid bits, the OOR flags, the counter and the output register.
REQ-032 SHALL hold wide_rvalid_o=0, wide_rdata_o=0 and busy_o=0 from the first clock edge with rst_ni low.
REQ-033 SHALL drop all in-flight responses when reset is asserted mid-operation, with no rvalid for them after deassertion.
REQ-034 SHALL keep wide_gnt_o and the sram_* outputs combinational, not gated by reset.

Structure
REQ-035 SHALL place the legal SramLatency range constants (1, 4) in memory_island_pkg.
REQ-036 SHALL use elaboration assertions to check SramLatency, NumWords>0 and WideDataWidth%8==0.
REQ-037 SHALL implement the valid/OOR shift register as sub-module memory_island_delay (parameterised depth and width, synchronous active-low reset).

Verification (WideDataWidth=64, NumWords=1024, SramLatency=1, RspReg=0 unless stated)
REQ-038 SHALL cover: write 0x00000010 strb 0xFF data 0xDEADBEEF_CAFEF00D, then read 0x00000010 -> rvalid 1 cycle after each gnt, read data 0xDEADBEEF_CAFEF00D, write rdata 0.
REQ-039 SHALL cover: 8 back-to-back reads, sram_gnt_i=1, SramLatency=3, RspReg=1 -> 8 gnts on consecutive cycles, 8 rvalids on consecutive cycles starting 4 cycles later, busy_o high throughout, low after the last.
REQ-040 SHALL cover: read 0x00002000 (index 1024, OOR) -> gnt same cycle, sram_req_o=0, rvalid next cycle with rdata 0; an OOR write leaves the SRAM contents unchanged.
REQ-041 SHALL cover: sram_gnt_i=0 for 3 cycles with a read pending -> wide_gnt_o=0 for those cycles, rvalid exactly 1 cycle after sram_gnt_i rises.
REQ-042 SHALL cover: reset pulsed with 2 reads in flight (SramLatency=3) -> no rvalid afterwards, busy_o=0, and the next read completes normally.
